mem_copy_ram: RTL and testbench
===============================

# mem_copy_ram

Parametrised single-clock data memory for the processor datapath, with a built-in block-copy engine used by the OS layer for process context save/restore. The CPU gets a one-cycle registered read/write port. The copy engine moves a contiguous range of words inside the array, handles overlapping ranges, and reports through a busy/done/error handshake. It is the generalised successor of the fixed 32×600 instruction/data RAM: width and depth are configurable, and reads are synchronous to the same clock edge as writes.

## Interface
Parameters:
- DATA_W, 32, word width in bits
- ADDR_W, 10, address width; must satisfy 2^ADDR_W ≥ DEPTH
- DEPTH, 600, number of words implemented (addresses 0..DEPTH-1)

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset; clears control state only, never the array contents
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_we  in  1  CPU write strobe
- cpu_re  in  1  CPU read strobe
- cpu_rdata  out  DATA_W  registered read data
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid this cycle
- cpu_stall  out  1  high while the copy engine owns the array
- err_oob  out  1  one-cycle pulse on any rejected access or copy request
- copy_start  in  1  copy request strobe
- copy_src  in  ADDR_W  first source address
- copy_dst  in  ADDR_W  first destination address
- copy_len  in  ADDR_W+1  number of words to copy (0..DEPTH)
- copy_busy  out  1  engine active
- copy_done  out  1  one-cycle completion pulse

## Operation
- Array contents: no reset; initialised only by an optional initial block/file load. rst never clears words.
- CPU port while idle, cpu_addr < DEPTH:
  - cpu_we: word written at the clock edge.
  - cpu_re: cpu_rdata is loaded at the same edge and cpu_rvalid pulses in the following cycle.
  - cpu_we and cpu_re together on the same address: read returns the old data (read-before-write).
- CPU access with cpu_addr ≥ DEPTH: write dropped; a read returns cpu_rdata = 0 with cpu_rvalid; err_oob pulses.
- While cpu_stall = 1: cpu_we and cpu_re are ignored, no cpu_rvalid is generated, and cpu_rdata holds its value.
- Copy request is sampled when copy_start = 1 and the FSM is IDLE. It is rejected (err_oob pulse, no copy_done, no write) if copy_src + copy_len > DEPTH or copy_dst + copy_len > DEPTH. Sums use ADDR_W+2 bits, so they cannot overflow.
- copy_start while the engine is busy is ignored, with no error.
- Copy direction:
  - copy_dst > copy_src: descending, last word first, so overlapping ranges copy correctly.
  - Otherwise: ascending.
  - copy_dst == copy_src: executes normally; words are rewritten unchanged.
- FSM states: IDLE, RD, WR, DONE.
  - IDLE→RD on an accepted start with len > 0.
  - IDLE→DONE on an accepted start with len = 0.
  - RD: reads the source word into an internal buffer. RD→WR.
  - WR: writes the buffer to the destination and decrements the remaining count. WR→RD if remaining > 0, else WR→DONE.
  - DONE: asserts copy_done. DONE→IDLE.
- copy_busy = cpu_stall = 1 exactly in RD and WR.
- A CPU request issued in the same cycle as an accepted copy_start is still serviced.

## Timing
- Reset values: cpu_rdata = 0, cpu_rvalid = 0, cpu_stall = 0, err_oob = 0, copy_busy = 0, copy_done = 0, FSM = IDLE, counters = 0.
- Read latency: 1 cycle from the cpu_re edge to cpu_rvalid.
- Copy of L > 0 words: copy_busy is high for exactly 2L cycles starting the cycle after the start edge. copy_done is high for 1 cycle immediately after, with copy_busy low.
- L = 0: copy_done pulses the cycle after start; copy_busy never rises.
- Rejected request: err_oob pulses the cycle after start; the FSM stays IDLE.
- rst asserted mid-copy: FSM goes to IDLE immediately and outputs take reset values. Words already written remain; no copy_done is issued.

## Test plan
- Write 0xDEADBEEF to address 5, then read address 5 → cpu_rvalid one cycle later with cpu_rdata = 0xDEADBEEF. Simultaneous write 0x1 / read at address 5 → returns 0xDEADBEEF; a later read returns 0x1.
- Read address 600 with DEPTH = 600 → cpu_rdata = 0, err_oob pulse. Write to address 700 → no array change, err_oob pulse.
- Load words 10..13 = {1,2,3,4}, copy src = 10, dst = 20, len = 4 → busy for 8 cycles, then done pulse; words 20..23 = {1,2,3,4}. A CPU write issued while busy is dropped.
- Overlap: words 10..13 = {1,2,3,4}, copy src = 10, dst = 12, len = 4 → words 12..15 = {1,2,3,4}. Reverse case src = 12, dst = 10 with words 12..15 = {1,2,3,4} → words 10..13 = {1,2,3,4}.
- copy_len = 0 → done the next cycle, no busy, no write. Request src = 598, len = 4 → err_oob, no done, memory unchanged.
- Start a len = 8 copy and assert rst after 5 busy cycles → busy and done fall to 0 immediately; the first 2 destination words are updated and the rest are unchanged; a new copy after reset completes normally.

Source files
------------

// File: rtl/mem_copy_ram.sv
// mem_copy_ram: single-clock data memory with a built-in block-copy engine.
//
// The CPU has a one-cycle registered read/write port. The copy engine moves
// a contiguous range of words inside the array, one word every two cycles
// (RD then WR). It copies descending when the destination is above the
// source, so overlapping ranges behave like memmove.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset (control only)
//   cpu_addr/wdata/we/re CPU access request
//   cpu_rdata/rvalid     registered read data and its one-cycle valid pulse
//   cpu_stall            engine owns the array (RD/WR); CPU requests ignored
//   err_oob              one-cycle pulse on a rejected access or copy request
//   copy_start/src/dst/len  copy request, sampled only while IDLE
//   copy_busy/done       engine active / one-cycle completion pulse
module mem_copy_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  output logic              err_oob,
  input  logic              copy_start,
  input  logic [ADDR_W-1:0] copy_src,
  input  logic [ADDR_W-1:0] copy_dst,
  input  logic [ADDR_W:0]   copy_len,
  output logic              copy_busy,
  output logic              copy_done
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W+1:0] DEPTH_S = (ADDR_W+2)'(DEPTH);

  // Array contents are never reset.
  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W:0]   remain;
  logic [DATA_W-1:0] cbuf;
  logic              desc;

  logic              cpu_ok;
  logic              cpu_in_range;
  logic [ADDR_W+1:0] src_end;
  logic [ADDR_W+1:0] dst_end;
  logic [ADDR_W-1:0] src_last;
  logic [ADDR_W-1:0] dst_last;
  logic              copy_reject;
  logic              copy_desc;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // CPU is serviced whenever the engine is not in RD/WR.
  assign cpu_ok       = (state == IDLE) || (state == DONE);
  assign cpu_in_range = {1'b0, cpu_addr} < DEPTH_A;

  // End addresses are one past the last word; the extra bits keep the
  // range check free of overflow.
  assign src_end     = {2'b00, copy_src} + {1'b0, copy_len};
  assign dst_end     = {2'b00, copy_dst} + {1'b0, copy_len};
  assign copy_reject = (src_end > DEPTH_S) || (dst_end > DEPTH_S);
  assign copy_desc   = copy_dst > copy_src;

  // Last word of each range, used as the starting point of a descending copy.
  assign src_last = ADDR_W'(src_end - (ADDR_W+2)'(1));
  assign dst_last = ADDR_W'(dst_end - (ADDR_W+2)'(1));

  // Single write port shared by the engine (WR only) and the CPU (idle only);
  // the two never overlap because the CPU is stalled in WR.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cpu_addr;
    mem_wdata = cpu_wdata;
    if (state == WR) begin
      mem_we    = 1'b1;
      mem_waddr = dst_ptr;
      mem_wdata = cbuf;
    end else if (cpu_ok && cpu_we && cpu_in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      cpu_stall  <= 1'b0;
      err_oob    <= 1'b0;
      copy_busy  <= 1'b0;
      copy_done  <= 1'b0;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      remain     <= '0;
      cbuf       <= '0;
      desc       <= 1'b0;
    end else begin
      cpu_rvalid <= 1'b0;
      err_oob    <= 1'b0;
      copy_done  <= 1'b0;

      // CPU port; the non-blocking read of mem gives read-before-write.
      if (cpu_ok) begin
        if (cpu_re) begin
          cpu_rvalid <= 1'b1;
          cpu_rdata  <= cpu_in_range ? mem[cpu_addr] : '0;
        end
        if ((cpu_re || cpu_we) && !cpu_in_range) begin
          err_oob <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (copy_start) begin
            if (copy_reject) begin
              err_oob <= 1'b1;
            end else if (copy_len == '0) begin
              state     <= DONE;
              copy_done <= 1'b1;
            end else begin
              state     <= RD;
              copy_busy <= 1'b1;
              cpu_stall <= 1'b1;
              remain    <= copy_len;
              desc      <= copy_desc;
              src_ptr   <= copy_desc ? src_last : copy_src;
              dst_ptr   <= copy_desc ? dst_last : copy_dst;
            end
          end
        end

        RD: begin
          cbuf  <= mem[src_ptr];
          state <= WR;
        end

        WR: begin
          remain  <= remain - 1'b1;
          src_ptr <= desc ? src_ptr - 1'b1 : src_ptr + 1'b1;
          dst_ptr <= desc ? dst_ptr - 1'b1 : dst_ptr + 1'b1;
          if (remain == (ADDR_W+1)'(1)) begin
            state     <= DONE;
            copy_done <= 1'b1;
            copy_busy <= 1'b0;
            cpu_stall <= 1'b0;
          end else begin
            state <= RD;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_ram.sv
module tb_mem_copy_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_stall;
  logic        err_oob;
  logic        copy_start;
  logic [9:0]  copy_src;
  logic [9:0]  copy_dst;
  logic [10:0] copy_len;
  logic        copy_busy;
  logic        copy_done;

  mem_copy_ram #(.DATA_W(32), .ADDR_W(10), .DEPTH(600)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_stall  (cpu_stall),
    .err_oob    (err_oob),
    .copy_start (copy_start),
    .copy_src   (copy_src),
    .copy_dst   (copy_dst),
    .copy_len   (copy_len),
    .copy_busy  (copy_busy),
    .copy_done  (copy_done)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] model [0:1023];
  logic [31:0] exp_q [$];
  logic [31:0] mon_e;

  typedef struct {
    logic        we;
    logic        re;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every read pushes its expected word; each rvalid pops one.
  always @(negedge clk) begin
    if (!rst && cpu_rvalid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rvalid_unexpected: got rvalid=1 rdata=%h expected no pending read", cpu_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rdata", cpu_rdata, mon_e);
      end
    end
  end

  task automatic cpu_write(input logic [9:0] a, input logic [31:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    if (a < 10'd600) model[a] = d;
    chk("wr_err", err_oob, (a >= 10'd600) ? 32'd1 : 32'd0);
  endtask

  task automatic cpu_read(input logic [9:0] a);
    cpu_addr = a; cpu_re = 1'b1;
    exp_q.push_back((a < 10'd600) ? model[a] : 32'h0);
    @(posedge clk); #1;
    cpu_re = 1'b0;
    chk("rd_rvalid", cpu_rvalid, 1);
  endtask

  task automatic run_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] l,
                          input bit inject);
    int          nb;
    bit          rej;
    logic [31:0] tmp [$];
    rej = (int'(s) + int'(l) > 600) || (int'(d) + int'(l) > 600);
    copy_src = s; copy_dst = d; copy_len = l; copy_start = 1'b1;
    @(posedge clk); #1;
    copy_start = 1'b0;
    if (rej) begin
      chk("rej_err", err_oob, 1);
      chk("rej_busy", copy_busy, 0);
      @(posedge clk); #1;
      chk("rej_done", copy_done, 0);
      chk("rej_err_pulse", err_oob, 0);
    end else if (l == 0) begin
      chk("len0_done", copy_done, 1);
      chk("len0_busy", copy_busy, 0);
      @(posedge clk); #1;
      chk("len0_done_pulse", copy_done, 0);
    end else begin
      chk("start_busy", copy_busy, 1);
      chk("start_stall", cpu_stall, 1);
      nb = 0;
      while (copy_busy && nb < 4 * int'(l) + 8) begin
        nb++;
        if (inject && nb == 2) begin
          // These must be ignored: no write to word 40, no rvalid.
          cpu_addr = 10'd40; cpu_wdata = 32'h00000BAD; cpu_we = 1'b1; cpu_re = 1'b1;
        end else begin
          cpu_we = 1'b0; cpu_re = 1'b0;
        end
        @(posedge clk); #1;
      end
      cpu_we = 1'b0; cpu_re = 1'b0;
      chk("busy_cycles", nb, 2 * int'(l));
      chk("done_after_busy", copy_done, 1);
      chk("busy_low_at_done", copy_busy, 0);
      @(posedge clk); #1;
      chk("done_pulse", copy_done, 0);
    end
    if (!rej) begin
      for (int i = 0; i < int'(l); i++) tmp.push_back(model[int'(s) + i]);
      for (int i = 0; i < int'(l); i++) model[int'(d) + i] = tmp[i];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 1'b0, 10'd5,    32'hDEADBEEF, 32'h0,        1'b0};
    vt[1] = '{1'b0, 1'b1, 10'd5,    32'h0,        32'hDEADBEEF, 1'b0};
    vt[2] = '{1'b1, 1'b1, 10'd5,    32'h1,        32'hDEADBEEF, 1'b0};
    vt[3] = '{1'b0, 1'b1, 10'd5,    32'h0,        32'h1,        1'b0};
    vt[4] = '{1'b0, 1'b1, 10'd600,  32'h0,        32'h0,        1'b1};
    vt[5] = '{1'b1, 1'b0, 10'd700,  32'h55,       32'h0,        1'b1};
    vt[6] = '{1'b1, 1'b0, 10'd599,  32'hA5A5A5A5, 32'h0,        1'b0};
    vt[7] = '{1'b0, 1'b1, 10'd599,  32'h0,        32'hA5A5A5A5, 1'b0};
    vt[8] = '{1'b0, 1'b1, 10'd1023, 32'h0,        32'h0,        1'b1};

    rst = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    copy_start = 1'b0; copy_src = '0; copy_dst = '0; copy_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata",  cpu_rdata,  0);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_stall",  cpu_stall,  0);
    chk("rst_err",    err_oob,    0);
    chk("rst_busy",   copy_busy,  0);
    chk("rst_done",   copy_done,  0);
    rst = 1'b0;
    @(posedge clk); #1;

    // CPU port vectors
    for (int i = 0; i < 9; i++) begin
      cpu_addr = vt[i].addr; cpu_wdata = vt[i].wdata;
      cpu_we = vt[i].we; cpu_re = vt[i].re;
      if (vt[i].re) exp_q.push_back(vt[i].exp_rdata);
      @(posedge clk); #1;
      cpu_we = 1'b0; cpu_re = 1'b0;
      if (vt[i].we && vt[i].addr < 10'd600) model[vt[i].addr] = vt[i].wdata;
      chk("vec_err", err_oob, vt[i].exp_err);
      if (vt[i].re) chk("vec_rvalid", cpu_rvalid, 1);
    end
    @(posedge clk); #1;
    chk("err_pulse_end", err_oob, 0);

    // Basic copy with a dropped CPU access while busy
    for (int i = 0; i < 4; i++) cpu_write(10'(10 + i), 32'(i + 1));
    for (int i = 0; i < 4; i++) cpu_write(10'(20 + i), 32'hEEEE0000 + 32'(i));
    cpu_write(10'd40, 32'h40404040);
    run_copy(10'd10, 10'd20, 11'd4, 1'b1);
    for (int i = 0; i < 4; i++) cpu_read(10'(20 + i));
    cpu_read(10'd40);

    // Overlap, both directions
    for (int i = 0; i < 4; i++) cpu_write(10'(14 + i), 32'hCCCC0000 + 32'(i));
    run_copy(10'd10, 10'd12, 11'd4, 1'b0);
    for (int i = 0; i < 4; i++) cpu_read(10'(12 + i));
    for (int i = 0; i < 4; i++) cpu_write(10'(12 + i), 32'(i + 1));
    for (int i = 0; i < 2; i++) cpu_write(10'(10 + i), 32'hBBBB0000 + 32'(i));
    run_copy(10'd12, 10'd10, 11'd4, 1'b0);
    for (int i = 0; i < 4; i++) cpu_read(10'(10 + i));

    // Zero length, rejected ranges, exact-fit range, same address
    cpu_write(10'd30, 32'h30303030);
    cpu_write(10'd31, 32'h31313131);
    run_copy(10'd5, 10'd30, 11'd0, 1'b0);
    run_copy(10'd598, 10'd30, 11'd4, 1'b0);
    run_copy(10'd0, 10'd597, 11'd4, 1'b0);
    cpu_read(10'd30);
    cpu_read(10'd31);
    for (int i = 0; i < 4; i++) cpu_write(10'(596 + i), 32'h59600000 + 32'(i));
    run_copy(10'd596, 10'd60, 11'd4, 1'b0);
    for (int i = 0; i < 4; i++) cpu_read(10'(60 + i));
    run_copy(10'd30, 10'd30, 11'd2, 1'b0);
    cpu_read(10'd30);
    cpu_read(10'd31);

    // Reset in the middle of an 8-word copy
    for (int i = 0; i < 8; i++) cpu_write(10'(100 + i), 32'h00001000 + 32'(i));
    for (int i = 0; i < 8; i++) cpu_write(10'(50 + i), 32'h00005000 + 32'(i));
    copy_src = 10'd100; copy_dst = 10'd50; copy_len = 11'd8; copy_start = 1'b1;
    @(posedge clk); #1;
    copy_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", copy_busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",  copy_busy, 0);
    chk("mid_rst_done",  copy_done, 0);
    chk("mid_rst_stall", cpu_stall, 0);
    @(posedge clk); #1;
    chk("mid_rst_no_done", copy_done, 0);
    rst = 1'b0;
    model[50] = model[100];
    model[51] = model[101];
    for (int i = 0; i < 8; i++) cpu_read(10'(50 + i));
    run_copy(10'd100, 10'd60, 11'd3, 1'b0);
    for (int i = 0; i < 3; i++) cpu_read(10'(60 + i));

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
